// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode encoding and the command payload for the ALU issue unit.
package alu_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CARD_W   = 5;
    localparam int unsigned RADDR_W  = 3;
    localparam int unsigned NUM_REGS = 1 << RADDR_W;

    // Card encoding as decoded by the attached ALU
    localparam logic [CARD_W-1:0] CARD_ADD   = 5'h00;
    localparam logic [CARD_W-1:0] CARD_SUB   = 5'h01;
    localparam logic [CARD_W-1:0] CARD_AND   = 5'h02;
    localparam logic [CARD_W-1:0] CARD_OR    = 5'h03;
    localparam logic [CARD_W-1:0] CARD_XOR   = 5'h04;
    localparam logic [CARD_W-1:0] CARD_PASSA = 5'h05;

    typedef struct packed {
        logic [CARD_W-1:0]  card;
        logic               cin;
        logic [RADDR_W-1:0] ra;
        logic [RADDR_W-1:0] rb;
        logic [RADDR_W-1:0] rd;
        logic               we;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_issue_unit_if.sv
// Command, preload, ALU-side, result and debug signals of the ALU issue unit.
interface alu_issue_unit_if;
    import alu_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [CARD_W-1:0]  cmd_card;
    logic               cmd_cin;
    logic [RADDR_W-1:0] cmd_ra;
    logic [RADDR_W-1:0] cmd_rb;
    logic [RADDR_W-1:0] cmd_rd;
    logic               cmd_we;
    logic               ld_en;
    logic [RADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0]  ld_data;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic               alu_cin;
    logic [CARD_W-1:0]  alu_card;
    logic [DATA_W-1:0]  alu_f;
    logic               alu_cout;
    logic               alu_zero;
    logic               res_valid;
    logic [DATA_W-1:0]  res_data;
    logic               flag_cout;
    logic               flag_zero;
    logic [RADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0]  dbg_data;

    modport slave (
        input  cmd_valid, cmd_card, cmd_cin, cmd_ra, cmd_rb, cmd_rd, cmd_we,
        input  ld_en, ld_addr, ld_data, alu_f, alu_cout, alu_zero, dbg_addr,
        output cmd_ready, alu_a, alu_b, alu_cin, alu_card,
        output res_valid, res_data, flag_cout, flag_zero, dbg_data
    );

    modport master (
        output cmd_valid, cmd_card, cmd_cin, cmd_ra, cmd_rb, cmd_rd, cmd_we,
        output ld_en, ld_addr, ld_data, alu_f, alu_cout, alu_zero, dbg_addr,
        input  cmd_ready, alu_a, alu_b, alu_cin, alu_card,
        input  res_valid, res_data, flag_cout, flag_zero, dbg_data
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered full/empty/count; push ignored when full, pop ignored when empty.
module cmd_fifo #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head_c = mem_q[rd_ptr_q];
    assign full   = full_q;
    assign empty  = empty_q;
    assign count  = count_q;

endmodule

// File: rtl/alu_issue_unit.sv
// Issue and write-back stage wrapped around an external combinational ALU:
// command FIFO -> operand read with forwarding -> registered ALU inputs -> result capture.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    alu_issue_unit_if.slave io
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    cmd_t             in_cmd_c;
    cmd_t             head_c;
    logic             push_c;
    logic             issue_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [DATA_W-1:0] opnd_a_c, opnd_b_c;

    logic [DATA_W-1:0]  rf_q [NUM_REGS];
    logic [DATA_W-1:0]  rf_d [NUM_REGS];
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic               alu_cin_q, alu_cin_d;
    logic [CARD_W-1:0]  alu_card_q, alu_card_d;
    logic               e_valid_q, e_valid_d;
    logic [RADDR_W-1:0] e_rd_q, e_rd_d;
    logic               e_we_q, e_we_d;
    logic               res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic               flag_cout_q, flag_cout_d;
    logic               flag_zero_q, flag_zero_d;

    assign in_cmd_c = '{card: io.cmd_card, cin: io.cmd_cin, ra: io.cmd_ra,
                        rb: io.cmd_rb, rd: io.cmd_rd, we: io.cmd_we};

    // Ready depends only on registered FIFO state, never on the same-cycle pop
    assign io.cmd_ready = rst_n && !fifo_full;
    assign push_c       = io.cmd_valid && io.cmd_ready;
    assign issue_c      = !fifo_empty;

    cmd_fifo #(
        .WIDTH(CMD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .wdata (in_cmd_c),
        .pop   (issue_c),
        .head_c(head_c),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CNT_W'(FIFO_DEPTH));

    // Operand priority: in-flight ALU result, then same-cycle preload, then register file
    always_comb begin
        opnd_a_c = rf_q[head_c.ra];
        opnd_b_c = rf_q[head_c.rb];
        if (io.ld_en && (io.ld_addr == head_c.ra)) opnd_a_c = io.ld_data;
        if (io.ld_en && (io.ld_addr == head_c.rb)) opnd_b_c = io.ld_data;
        if (e_valid_q && e_we_q && (e_rd_q == head_c.ra)) opnd_a_c = io.alu_f;
        if (e_valid_q && e_we_q && (e_rd_q == head_c.rb)) opnd_b_c = io.alu_f;
    end

    always_comb begin
        rf_d        = rf_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_card_d  = alu_card_q;
        e_valid_d   = 1'b0;
        e_rd_d      = e_rd_q;
        e_we_d      = e_we_q;
        res_valid_d = e_valid_q;
        res_data_d  = res_data_q;
        flag_cout_d = flag_cout_q;
        flag_zero_d = flag_zero_q;

        // ALU write-back is applied last so it wins over a preload to the same register
        if (io.ld_en) rf_d[io.ld_addr] = io.ld_data;
        if (e_valid_q) begin
            if (e_we_q) rf_d[e_rd_q] = io.alu_f;
            res_data_d  = io.alu_f;
            flag_cout_d = io.alu_cout;
            flag_zero_d = io.alu_zero;
        end

        if (issue_c) begin
            alu_a_d    = opnd_a_c;
            alu_b_d    = opnd_b_c;
            alu_cin_d  = head_c.cin;
            alu_card_d = head_c.card;
            e_valid_d  = 1'b1;
            e_rd_d     = head_c.rd;
            e_we_d     = head_c.we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_q        <= '{default: '0};
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_card_q  <= '0;
            e_valid_q   <= 1'b0;
            e_rd_q      <= '0;
            e_we_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            flag_cout_q <= 1'b0;
            flag_zero_q <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_card_q  <= alu_card_d;
            e_valid_q   <= e_valid_d;
            e_rd_q      <= e_rd_d;
            e_we_q      <= e_we_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            flag_cout_q <= flag_cout_d;
            flag_zero_q <= flag_zero_d;
        end
    end

    assign io.alu_a     = alu_a_q;
    assign io.alu_b     = alu_b_q;
    assign io.alu_cin   = alu_cin_q;
    assign io.alu_card  = alu_card_q;
    assign io.res_valid = res_valid_q;
    assign io.res_data  = res_data_q;
    assign io.flag_cout = flag_cout_q;
    assign io.flag_zero = flag_zero_q;
    assign io.dbg_data  = rf_q[io.dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit with a behavioural ALU attached, plus a standalone stall test of cmd_fifo.
module tb_alu_issue_unit;
    import alu_pkg::*;

    localparam int unsigned XW = DATA_W + 1;
    localparam int NV = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_unit_if io ();

    alu_issue_unit #(.FIFO_DEPTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    // Standalone FIFO whose pop is under bench control, so it can be driven full
    logic       f_push = 1'b0, f_pop = 1'b0;
    logic [7:0] f_wdata = 8'h00, f_head;
    logic       f_full, f_empty;
    logic [2:0] f_count;

    cmd_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(f_push), .wdata(f_wdata), .pop(f_pop),
        .head_c(f_head), .full(f_full), .empty(f_empty), .count(f_count)
    );

    function automatic logic [DATA_W:0] alu_ref(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                input logic cin, input logic [CARD_W-1:0] card);
        case (card)
            CARD_ADD: return {1'b0, a} + {1'b0, b} + XW'(cin);
            CARD_SUB: return {1'b0, a} + {1'b0, ~b} + XW'(cin);
            CARD_AND: return {1'b0, a & b};
            CARD_OR:  return {1'b0, a | b};
            CARD_XOR: return {1'b0, a ^ b};
            default:  return {1'b0, a};
        endcase
    endfunction

    logic [DATA_W:0] alu_res;
    assign alu_res     = alu_ref(io.alu_a, io.alu_b, io.alu_cin, io.alu_card);
    assign io.alu_f    = alu_res[DATA_W-1:0];
    assign io.alu_cout = alu_res[DATA_W];
    assign io.alu_zero = (alu_res[DATA_W-1:0] == '0);

    typedef struct {
        logic [DATA_W-1:0] f;
        logic              cout;
        logic              zero;
        int                cyc;
    } exp_t;

    typedef struct {
        logic [CARD_W-1:0]  card;
        logic               cin;
        logic               we;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [DATA_W-1:0]  f;
        logic               cout;
        logic               zero;
        logic [DATA_W-1:0]  rd_val;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[NV];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: every strobe must match the oldest expectation, two edges after its accept
    always @(negedge clk) begin : mon
        exp_t e;
        if (io.res_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_res_valid", 64'(io.res_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("res_data", 64'(io.res_data), 64'(e.f));
                check("flag_cout", 64'(io.flag_cout), 64'(e.cout));
                check("flag_zero", 64'(io.flag_zero), 64'(e.zero));
                check("res_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic preload(input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        io.ld_en   = 1'b1;
        io.ld_addr = a;
        io.ld_data = d;
        step();
        io.ld_en = 1'b0;
    endtask

    task automatic drive_cmd(input logic [CARD_W-1:0] card, input logic cin, input logic [RADDR_W-1:0] ra,
                             input logic [RADDR_W-1:0] rb, input logic [RADDR_W-1:0] rd, input logic we);
        io.cmd_valid = 1'b1;
        io.cmd_card  = card;
        io.cmd_cin   = cin;
        io.cmd_ra    = ra;
        io.cmd_rb    = rb;
        io.cmd_rd    = rd;
        io.cmd_we    = we;
    endtask

    task automatic send(input logic [CARD_W-1:0] card, input logic cin, input logic [RADDR_W-1:0] ra,
                        input logic [RADDR_W-1:0] rb, input logic [RADDR_W-1:0] rd, input logic we,
                        input bit exp_res, input logic [DATA_W-1:0] f, input logic cout, input logic zero);
        drive_cmd(card, cin, ra, rb, rd, we);
        check("cmd_ready_on_send", 64'(io.cmd_ready), 64'(1));
        if (exp_res) sb_q.push_back('{f: f, cout: cout, zero: zero, cyc: cyc + 3});
        step();
        io.cmd_valid = 1'b0;
    endtask

    task automatic check_dbg(input string name, input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        io.dbg_addr = a;
        #1;
        check(name, 64'(io.dbg_data), 64'(exp));
    endtask

    task automatic check_reset_state(input logic exp_ready);
        check("rst_cmd_ready", 64'(io.cmd_ready), 64'(exp_ready));
        check("rst_res_valid", 64'(io.res_valid), 64'(0));
        check("rst_alu_a", 64'(io.alu_a), 64'(0));
        check("rst_alu_b", 64'(io.alu_b), 64'(0));
        check("rst_alu_cin", 64'(io.alu_cin), 64'(0));
        check("rst_alu_card", 64'(io.alu_card), 64'(0));
        check("rst_res_data", 64'(io.res_data), 64'(0));
        check("rst_flag_cout", 64'(io.flag_cout), 64'(0));
        check("rst_flag_zero", 64'(io.flag_zero), 64'(0));
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            io.dbg_addr = RADDR_W'(r);
            #1;
            check($sformatf("rst_reg%0d", r), 64'(io.dbg_data), 64'(0));
        end
    endtask

    initial begin
        vecs[0] = '{CARD_ADD, 1'b0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b1, 32'h0};
        vecs[1] = '{CARD_ADD, 1'b1, 1'b1, 3'd4, 32'h5,         32'h7,         32'hD,         1'b0, 1'b0, 32'hD};
        vecs[2] = '{CARD_SUB, 1'b1, 1'b1, 3'd5, 32'hA,         32'h3,         32'h7,         1'b1, 1'b0, 32'h7};
        vecs[3] = '{CARD_SUB, 1'b1, 1'b1, 3'd3, 32'h3,         32'h3,         32'h0,         1'b1, 1'b1, 32'h0};
        vecs[4] = '{CARD_SUB, 1'b1, 1'b1, 3'd4, 32'h3,         32'hA,         32'hFFFF_FFF9, 1'b0, 1'b0, 32'hFFFF_FFF9};
        vecs[5] = '{CARD_AND, 1'b0, 1'b1, 3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 32'hF000_F000};
        vecs[6] = '{CARD_OR,  1'b0, 1'b1, 3'd6, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};
        vecs[7] = '{CARD_XOR, 1'b0, 1'b1, 3'd7, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h5A5A_5A5A};
        vecs[8] = '{CARD_ADD, 1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[9] = '{CARD_ADD, 1'b0, 1'b0, 3'd7, 32'h1,         32'h2,         32'h3,         1'b0, 1'b0, 32'h5A5A_5A5A};

        io.ld_en    = 1'b0;
        io.ld_addr  = '0;
        io.ld_data  = '0;
        io.dbg_addr = '0;
        drive_cmd(CARD_ADD, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1);

        // Reset held for three edges with a command offered
        idle(3);
        check_reset_state(1'b0);
        io.cmd_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("ready_after_release", 64'(io.cmd_ready), 64'(1));

        // Stalled FIFO: fill to four, fifth push refused, then wrap-around order
        for (int i = 0; i < 5; i++) begin
            f_push  = 1'b1;
            f_wdata = 8'h10 + 8'(i);
            step();
        end
        f_push = 1'b0;
        check("fifo_count_full", 64'(f_count), 64'(4));
        check("fifo_full", 64'(f_full), 64'(1));
        check("fifo_head_after_fill", 64'(f_head), 64'(8'h10));
        f_push = 1'b1; f_wdata = 8'h20; f_pop = 1'b1;
        step();
        check("fifo_push_refused_when_full", 64'(f_count), 64'(3));
        f_wdata = 8'h21;
        step();
        check("fifo_push_pop_count", 64'(f_count), 64'(3));
        f_push = 1'b0; f_pop = 1'b0;
        begin
            logic [7:0] exp_order [3];
            exp_order = '{8'h12, 8'h13, 8'h21};
            for (int i = 0; i < 3; i++) begin
                check($sformatf("fifo_order%0d", i), 64'(f_head), 64'(exp_order[i]));
                f_pop = 1'b1;
                step();
                f_pop = 1'b0;
            end
        end
        check("fifo_empty_after_drain", 64'(f_empty), 64'(1));
        check("fifo_count_after_drain", 64'(f_count), 64'(0));

        // Table of single operations on r1/r2
        for (int i = 0; i < NV; i++) begin
            preload(3'd1, vecs[i].a);
            preload(3'd2, vecs[i].b);
            send(vecs[i].card, vecs[i].cin, 3'd1, 3'd2, vecs[i].rd, vecs[i].we,
                 1'b1, vecs[i].f, vecs[i].cout, vecs[i].zero);
            idle(3);
            check_dbg($sformatf("vec%0d_rd_value", i), vecs[i].rd, vecs[i].rd_val);
        end

        // Dependent back-to-back ops: r3 = r1 + r2, r4 = r3 + r1
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd7);
        send(CARD_ADD, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0);
        send(CARD_ADD, 1'b0, 3'd3, 3'd1, 3'd4, 1'b1, 1'b1, 32'd17, 1'b0, 1'b0);
        idle(3);
        check_dbg("fwd_r3", 3'd3, 32'd12);
        check_dbg("fwd_r4", 3'd4, 32'd17);

        // Preload to r1 on the issue edge is forwarded into the operand
        send(CARD_ADD, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 32'd107, 1'b0, 1'b0);
        preload(3'd1, 32'd100);
        idle(3);
        check_dbg("ldfwd_r3", 3'd3, 32'd107);

        // Write-back and preload collide on r5: ALU value wins
        send(CARD_ADD, 1'b0, 3'd1, 3'd2, 3'd5, 1'b1, 1'b1, 32'd107, 1'b0, 1'b0);
        step();
        preload(3'd5, 32'hDEAD);
        idle(2);
        check_dbg("collision_r5", 3'd5, 32'd107);

        // Write-back and preload on different registers both land
        send(CARD_ADD, 1'b0, 3'd1, 3'd2, 3'd6, 1'b1, 1'b1, 32'd107, 1'b0, 1'b0);
        step();
        preload(3'd7, 32'hBEEF);
        idle(2);
        check_dbg("split_r6", 3'd6, 32'd107);
        check_dbg("split_r7", 3'd7, 32'hBEEF);

        // Six consecutive commands with continuous issue: ready never drops
        for (int i = 0; i < 6; i++) begin
            send(CARD_ADD, 1'(i & 1), 3'd1, 3'd2, 3'd0, 1'b0, 1'b1,
                 32'd107 + 32'(i & 1), 1'b0, 1'b0);
        end
        idle(3);

        // Reset with two commands in flight and a third offered
        send(CARD_ADD, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        send(CARD_ADD, 1'b0, 3'd1, 3'd2, 3'd4, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        drive_cmd(CARD_SUB, 1'b1, 3'd1, 3'd2, 3'd5, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd_ready_low", 64'(io.cmd_ready), 64'(0));
        idle(3);
        check_reset_state(1'b0);
        io.cmd_valid = 1'b0;
        rst_n = 1'b1;
        step();
        idle(4);
        check_reset_state(1'b1);

        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
